issue_entry_fifo: RTL and testbench

Decoded-instruction queue between the decoder and the issue reorder stage. It buffers up to DEPTH scoreboard entries in program order and presents the oldest entry on the same valid/ack handshake the reorder stage consumes. Its job is to absorb decoder bursts while the issue side stalls, for example when the LSU is busy or a control-flow instruction is held. It adds no combinational path from issue_instr_ack_i to decoded_ready_o.

---
 rtl/ariane_pkg.sv | 17 +
 rtl/issue_entry_fifo.sv | 101 ++++++++++
 tb/tb_issue_entry_fifo.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Scoreboard entry type shared between decoder, issue FIFO and reorder stage.
package ariane_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  trans_id;
    logic [3:0]  fu;
    logic [7:0]  op;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [5:0]  rd;
    logic [31:0] result;
    logic        valid;
    logic        use_imm;
  } scoreboard_entry_t;

endpackage

// File: rtl/issue_entry_fifo.sv
// Program-order queue of decoded scoreboard entries feeding the issue reorder stage.
// Ready depends only on the stored count, so issue ack never reaches decoded_ready_o.
module issue_entry_fifo #(
  parameter int unsigned DEPTH        = 4,
  parameter bit          FALL_THROUGH = 1'b0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  ariane_pkg::scoreboard_entry_t     decoded_entry_i,
  input  logic                              decoded_valid_i,
  input  logic                              decoded_is_ctrl_flow_i,
  output logic                              decoded_ready_o,
  output ariane_pkg::scoreboard_entry_t     issue_entry_o,
  output logic                              issue_entry_valid_o,
  output logic                              is_ctrl_flow_o,
  input  logic                              issue_instr_ack_i,
  output logic [$clog2(DEPTH+1)-1:0]        usage_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  typedef struct packed {
    ariane_pkg::scoreboard_entry_t sbe;
    logic                          ctrl;
  } slot_t;

  slot_t            mem_q [DEPTH];
  slot_t            last_q;
  slot_t            in_slot;
  slot_t            head;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             empty, head_valid;
  logic             push, pop, wr_en, rd_en;

  assign empty           = (cnt_q == '0);
  assign decoded_ready_o = (cnt_q != CntW'(DEPTH));
  assign usage_o         = cnt_q;
  assign in_slot         = '{sbe: decoded_entry_i, ctrl: decoded_is_ctrl_flow_i};

  always_comb begin
    head       = last_q;
    head_valid = 1'b0;
    if (!empty) begin
      head       = mem_q[rd_ptr_q];
      head_valid = 1'b1;
    end else if (FALL_THROUGH) begin
      head       = in_slot;
      head_valid = decoded_valid_i;
    end
    if (flush_i) head_valid = 1'b0;
  end

  assign issue_entry_o       = head.sbe;
  assign is_ctrl_flow_o      = head.ctrl;
  assign issue_entry_valid_o = head_valid;

  assign push  = decoded_valid_i & decoded_ready_o & ~flush_i;
  assign pop   = head_valid & issue_instr_ack_i & ~flush_i;
  // Pop while empty is a fall-through bypass: the entry is consumed without being stored.
  assign wr_en = push & ~(pop & empty);
  assign rd_en = pop & ~empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && !rd_en)      cnt_d = cnt_q + 1'b1;
      else if (rd_en && !wr_en) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      if (pop) last_q <= head;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_slot;
  end

endmodule

// File: tb/tb_issue_entry_fifo.sv
// Bench for issue_entry_fifo: FALL_THROUGH=0 and =1 instances share stimulus, each checked against a queue model.
module tb_issue_entry_fifo;
  import ariane_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH+1);

  typedef struct packed {
    scoreboard_entry_t sbe;
    logic              ctrl;
  } slot_t;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              flush = 1'b0, dvalid = 1'b0, dctrl = 1'b0, ack = 1'b0;
  scoreboard_entry_t dentry = '0;

  scoreboard_entry_t ent_o [2];
  logic              val_o [2];
  logic              ctrl_o [2];
  logic              rdy_o [2];
  logic [CW-1:0]     use_o [2];

  int checks = 0;
  int errors = 0;

  scoreboard_entry_t ea [8];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    issue_entry_fifo #(
      .DEPTH        (DEPTH),
      .FALL_THROUGH (1'(g))
    ) dut (
      .clk_i                  (clk),
      .rst_ni                 (rst_ni),
      .flush_i                (flush),
      .decoded_entry_i        (dentry),
      .decoded_valid_i        (dvalid),
      .decoded_is_ctrl_flow_i (dctrl),
      .decoded_ready_o        (rdy_o[g]),
      .issue_entry_o          (ent_o[g]),
      .issue_entry_valid_o    (val_o[g]),
      .is_ctrl_flow_o         (ctrl_o[g]),
      .issue_instr_ack_i      (ack),
      .usage_o                (use_o[g])
    );

    slot_t q[$];
    slot_t eh;
    logic  ev, er, epush, epop;

    always @(negedge clk) begin
      if (!rst_ni) begin
        q.delete();
        chk($sformatf("dut%0d.reset.valid", g), 128'(val_o[g]), 128'(0));
        chk($sformatf("dut%0d.reset.usage", g), 128'(use_o[g]), 128'(0));
        chk($sformatf("dut%0d.reset.ready", g), 128'(rdy_o[g]), 128'(1));
        if (g == 0) begin
          chk("dut0.reset.entry", 128'(ent_o[g]), 128'(0));
          chk("dut0.reset.ctrl", 128'(ctrl_o[g]), 128'(0));
        end
      end else begin
        er = (q.size() != DEPTH);
        ev = 1'b0;
        eh = '0;
        if (q.size() != 0) begin
          ev = 1'b1;
          eh = q[0];
        end else if (g == 1) begin
          ev = dvalid;
          eh = '{sbe: dentry, ctrl: dctrl};
        end
        if (flush) ev = 1'b0;
        chk($sformatf("dut%0d.ready", g), 128'(rdy_o[g]), 128'(er));
        chk($sformatf("dut%0d.usage", g), 128'(use_o[g]), 128'(q.size()));
        chk($sformatf("dut%0d.valid", g), 128'(val_o[g]), 128'(ev));
        if (ev) begin
          chk($sformatf("dut%0d.entry", g), 128'(ent_o[g]), 128'(eh.sbe));
          chk($sformatf("dut%0d.ctrl", g), 128'(ctrl_o[g]), 128'(eh.ctrl));
        end
        epush = dvalid && er && !flush;
        epop  = ev && ack && !flush;
        if (flush) q.delete();
        else begin
          if (epop && q.size() != 0) void'(q.pop_front());
          else if (epop) epush = 1'b0;
          if (epush) q.push_back('{sbe: dentry, ctrl: dctrl});
        end
      end
    end
  end

  function automatic scoreboard_entry_t rnd_e();
    scoreboard_entry_t e;
    e          = '0;
    e.pc       = $urandom;
    e.trans_id = 3'($urandom);
    e.op       = 8'($urandom);
    e.rd       = 6'($urandom);
    e.result   = $urandom;
    e.valid    = 1'($urandom);
    return e;
  endfunction

  task automatic drive(input bit v, input scoreboard_entry_t e, input bit c, input bit a, input bit f);
    dvalid = v;
    dentry = e;
    dctrl  = c;
    ack    = a;
    flush  = f;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ea[i] = rnd_e();
    drive(0, '0, 0, 0, 0);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_ni = 1'b1;
    nxt();

    // fill A..D with ack low, then a fifth offer that must not be stored
    for (int i = 0; i < 4; i++) begin
      drive(1, ea[i], 1'(i), 0, 0);
      nxt();
    end
    drive(1, ea[4], 1, 0, 0);
    smp();
    chk("fill.usage", 128'(use_o[0]), 128'(4));
    chk("fill.ready", 128'(rdy_o[0]), 128'(0));
    chk("fill.head", 128'(ent_o[0]), 128'(ea[0]));
    nxt();
    drive(0, '0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("drain.usage", 128'(use_o[0]), 128'(4 - i));
      chk("drain.entry", 128'(ent_o[0]), 128'(ea[i]));
      chk("drain.ctrl", 128'(ctrl_o[0]), 128'(i % 2));
      nxt();
    end
    smp();
    chk("drain.valid0", 128'(val_o[0]), 128'(0));
    chk("drain.usage0", 128'(use_o[0]), 128'(0));
    chk("drain.usage1", 128'(use_o[1]), 128'(0));
    nxt();

    // full with simultaneous pop
    for (int i = 0; i < 4; i++) begin
      drive(1, ea[i], 0, 0, 0);
      nxt();
    end
    drive(1, ea[5], 1, 1, 0);
    smp();
    chk("fullpop.usage", 128'(use_o[0]), 128'(4));
    chk("fullpop.ready", 128'(rdy_o[0]), 128'(0));
    nxt();
    drive(1, ea[5], 1, 0, 0);
    smp();
    chk("fullpop.usage_after", 128'(use_o[0]), 128'(3));
    chk("fullpop.ready_after", 128'(rdy_o[0]), 128'(1));
    nxt();
    drive(0, '0, 0, 0, 0);
    smp();
    chk("fullpop.accepted", 128'(use_o[0]), 128'(4));
    nxt();
    drive(0, '0, 0, 1, 0);
    repeat (5) nxt();

    // flush with push and ack active
    for (int i = 0; i < 3; i++) begin
      drive(1, ea[i], 0, 0, 0);
      nxt();
    end
    drive(1, ea[6], 0, 1, 1);
    smp();
    chk("flush.valid0", 128'(val_o[0]), 128'(0));
    chk("flush.valid1", 128'(val_o[1]), 128'(0));
    chk("flush.usage", 128'(use_o[0]), 128'(3));
    nxt();
    drive(0, '0, 0, 0, 0);
    smp();
    chk("flush.usage0_after", 128'(use_o[0]), 128'(0));
    chk("flush.usage1_after", 128'(use_o[1]), 128'(0));
    nxt();

    // fall-through while empty, ack high then ack low
    drive(1, ea[7], 1, 1, 0);
    smp();
    chk("ft.valid", 128'(val_o[1]), 128'(1));
    chk("ft.entry", 128'(ent_o[1]), 128'(ea[7]));
    chk("ft.ctrl", 128'(ctrl_o[1]), 128'(1));
    chk("ft.usage", 128'(use_o[1]), 128'(0));
    chk("noft.valid", 128'(val_o[0]), 128'(0));
    nxt();
    drive(0, '0, 0, 0, 0);
    smp();
    chk("ft.usage_after", 128'(use_o[1]), 128'(0));
    chk("noft.usage_after", 128'(use_o[0]), 128'(1));
    nxt();
    drive(0, '0, 0, 1, 0);
    nxt();
    drive(1, ea[3], 1, 0, 0);
    smp();
    chk("ft.hold_valid", 128'(val_o[1]), 128'(1));
    nxt();
    drive(0, '0, 0, 0, 0);
    smp();
    chk("ft.stored_usage", 128'(use_o[1]), 128'(1));
    chk("ft.stored_entry", 128'(ent_o[1]), 128'(ea[3]));
    chk("ft.stored_ctrl", 128'(ctrl_o[1]), 128'(1));
    nxt();
    drive(0, '0, 0, 1, 0);
    repeat (3) nxt();

    // asynchronous reset with two entries stored
    for (int i = 0; i < 2; i++) begin
      drive(1, ea[i], 0, 0, 0);
      nxt();
    end
    drive(0, '0, 0, 0, 0);
    chk("areset.pre_usage", 128'(use_o[0]), 128'(2));
    #1 rst_ni = 1'b0;
    #1;
    chk("areset.valid0", 128'(val_o[0]), 128'(0));
    chk("areset.valid1", 128'(val_o[1]), 128'(0));
    chk("areset.usage0", 128'(use_o[0]), 128'(0));
    chk("areset.usage1", 128'(use_o[1]), 128'(0));
    chk("areset.ready0", 128'(rdy_o[0]), 128'(1));
    @(negedge clk);
    #2 rst_ni = 1'b1;
    nxt();
    drive(1, ea[2], 0, 0, 0);
    smp();
    chk("areset.push_lat", 128'(val_o[0]), 128'(0));
    nxt();
    drive(0, '0, 0, 0, 0);
    smp();
    chk("areset.push_valid", 128'(val_o[0]), 128'(1));
    chk("areset.push_entry", 128'(ent_o[0]), 128'(ea[2]));
    nxt();
    drive(0, '0, 0, 1, 0);
    repeat (2) nxt();

    // streaming: valid and ack held high across several pointer wraps
    for (int i = 0; i < 20; i++) begin
      drive(1, rnd_e(), 1'($urandom), 1, 0);
      smp();
      if (i > 0) chk("stream.usage0", 128'(use_o[0]), 128'(1));
      chk("stream.usage1", 128'(use_o[1]), 128'(0));
      nxt();
    end
    drive(0, '0, 0, 1, 0);
    repeat (2) nxt();

    // randomized phases with varying push/ack pressure
    for (int p = 0; p < 8; p++) begin
      int unsigned vth;
      int unsigned ath;
      vth = $urandom_range(0, 3);
      ath = $urandom_range(0, 3);
      repeat (100) begin
        drive($urandom_range(0, 3) <= vth, rnd_e(), 1'($urandom),
              $urandom_range(0, 3) <= ath, $urandom_range(0, 31) == 0);
        nxt();
      end
    end
    drive(0, '0, 0, 1, 0);
    repeat (6) nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
